cpu_controller: RTL and testbench

//   Phase sequencer for the 8-bit accumulator CPU. Steps an 8-phase instruction cycle
//   (fetch, decode, operand fetch, execute, store) and decodes phase+opcode into the control

---
 rtl/cpu_controller_if.sv | 39 +++
 rtl/cpu_controller.sv | 163 ++++++++++++++++
 tb/tb_cpu_controller.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_controller_if.sv
// Control interface between the CPU phase sequencer and the datapath.
// The controller side is the master: it samples opcode/zero (and step when
// SINGLE_STEP_EN is defined) and drives every control strobe plus the phase trace.
interface cpu_ctrl_if #(
    parameter int OP_W    = 3,
    parameter int PHASE_W = 3
);
    logic [OP_W-1:0]    opcode;
    logic               zero;
`ifdef SINGLE_STEP_EN
    logic               step;
`endif
    logic               sel;
    logic               rd;
    logic               ld_ir;
    logic               inc_pc;
    logic               ld_pc;
    logic               ld_ac;
    logic               data_e;
    logic               wr;
    logic               halt;
    logic [PHASE_W-1:0] phase;

    modport master (
`ifdef SINGLE_STEP_EN
        input  step,
`endif
        input  opcode, zero,
        output sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, data_e, wr, halt, phase
    );

    modport slave (
`ifdef SINGLE_STEP_EN
        output step,
`endif
        output opcode, zero,
        input  sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, data_e, wr, halt, phase
    );
endinterface

// File: rtl/cpu_controller.sv
// Phase sequencer for the 8-bit accumulator CPU.
// Steps an 8-phase instruction cycle and decodes phase+opcode into datapath strobes.
// Optional feature: SINGLE_STEP_EN adds a step input that parks the sequencer
// at phase 0 after each instruction until step is sampled high.
//
// state         | meaning
// --------------+-----------------------------------------------
// PH_INST_ADDR  | 0: present PC on memory address
// PH_INST_FETCH | 1: read instruction
// PH_INST_LOAD  | 2: load instruction register
// PH_IDLE       | 3: IR settles
// PH_OP_ADDR    | 4: bump PC, catch HLT
// PH_OP_FETCH   | 5: read operand (ALU ops)
// PH_ALU_OP     | 6: execute / skip / start jump / drive store data
// PH_STORE      | 7: write back / finish jump
// halted_q      | sticky halt, phase frozen at PH_OP_FETCH
module cpu_controller #(
    parameter int OP_W    = 3,
    parameter int PHASE_W = 3
) (
    input  logic     clk,
    input  logic     rst_,
    cpu_ctrl_if.master bus
);
    localparam logic [OP_W-1:0] OP_HLT = OP_W'(0);
    localparam logic [OP_W-1:0] OP_SKZ = OP_W'(1);
    localparam logic [OP_W-1:0] OP_ADD = OP_W'(2);
    localparam logic [OP_W-1:0] OP_AND = OP_W'(3);
    localparam logic [OP_W-1:0] OP_XOR = OP_W'(4);
    localparam logic [OP_W-1:0] OP_LDA = OP_W'(5);
    localparam logic [OP_W-1:0] OP_STO = OP_W'(6);
    localparam logic [OP_W-1:0] OP_JMP = OP_W'(7);

    typedef enum logic [PHASE_W-1:0] {
        PH_INST_ADDR  = PHASE_W'(0),
        PH_INST_FETCH = PHASE_W'(1),
        PH_INST_LOAD  = PHASE_W'(2),
        PH_IDLE       = PHASE_W'(3),
        PH_OP_ADDR    = PHASE_W'(4),
        PH_OP_FETCH   = PHASE_W'(5),
        PH_ALU_OP     = PHASE_W'(6),
        PH_STORE      = PHASE_W'(7)
    } phase_e;

    phase_e phase_q, phase_d;
    logic   halted_q, halted_d;
`ifdef SINGLE_STEP_EN
    logic   wait_q, wait_d;
`endif

    logic is_aluop;
    logic is_hlt;
    logic is_skz;
    logic is_sto;
    logic is_jmp;

    assign is_aluop = (bus.opcode == OP_ADD) || (bus.opcode == OP_AND) ||
                      (bus.opcode == OP_XOR) || (bus.opcode == OP_LDA);
    assign is_hlt   = (bus.opcode == OP_HLT);
    assign is_skz   = (bus.opcode == OP_SKZ);
    assign is_sto   = (bus.opcode == OP_STO);
    assign is_jmp   = (bus.opcode == OP_JMP);

    // State register: phase counter, sticky halt and (optionally) the step wait flag.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            phase_q  <= PH_INST_ADDR;
            halted_q <= 1'b0;
`ifdef SINGLE_STEP_EN
            wait_q   <= 1'b0;
`endif
        end else begin
            phase_q  <= phase_d;
            halted_q <= halted_d;
`ifdef SINGLE_STEP_EN
            wait_q   <= wait_d;
`endif
        end
    end

    // Next phase: free-running increment, HLT freezes at OP_FETCH, optional park at 0.
    always_comb begin
        phase_d  = phase_e'(phase_q + PHASE_W'(1));
        halted_d = halted_q;
`ifdef SINGLE_STEP_EN
        wait_d   = wait_q;
`endif
        if (halted_q) begin
            phase_d = phase_q;
        end else if (phase_q == PH_OP_ADDR && is_hlt) begin
            halted_d = 1'b1;
            phase_d  = PH_OP_FETCH;
        end
`ifdef SINGLE_STEP_EN
        else if (phase_q == PH_STORE) begin
            phase_d = PH_INST_ADDR;
            wait_d  = 1'b1;
        end else if (phase_q == PH_INST_ADDR && wait_q) begin
            if (bus.step) begin
                wait_d = 1'b0;
            end else begin
                phase_d = PH_INST_ADDR;
            end
        end
`endif
    end

    // Output decode: purely combinational from phase, opcode, zero and halt state.
    always_comb begin
        bus.sel    = 1'b0;
        bus.rd     = 1'b0;
        bus.ld_ir  = 1'b0;
        bus.inc_pc = 1'b0;
        bus.ld_pc  = 1'b0;
        bus.ld_ac  = 1'b0;
        bus.data_e = 1'b0;
        bus.wr     = 1'b0;
        bus.halt   = 1'b0;
        if (halted_q) begin
            bus.halt = 1'b1;
        end else begin
            unique case (phase_q)
                PH_INST_ADDR: begin
                    bus.sel = 1'b1;
                end
                PH_INST_FETCH: begin
                    bus.sel = 1'b1;
                    bus.rd  = 1'b1;
                end
                PH_INST_LOAD, PH_IDLE: begin
                    bus.sel   = 1'b1;
                    bus.rd    = 1'b1;
                    bus.ld_ir = 1'b1;
                end
                PH_OP_ADDR: begin
                    bus.inc_pc = 1'b1;
                    bus.halt   = is_hlt;
                end
                PH_OP_FETCH: begin
                    bus.rd = is_aluop;
                end
                PH_ALU_OP: begin
                    bus.rd     = is_aluop;
                    bus.ld_ac  = is_aluop;
                    bus.inc_pc = is_skz && bus.zero;
                    bus.ld_pc  = is_jmp;
                    bus.data_e = is_sto;
                end
                PH_STORE: begin
                    bus.rd     = is_aluop;
                    bus.ld_ac  = is_aluop;
                    bus.inc_pc = is_jmp;
                    bus.ld_pc  = is_jmp;
                    bus.data_e = is_sto;
                    bus.wr     = is_sto;
                end
                default: ;
            endcase
        end
    end

    assign bus.phase = phase_q;
endmodule

// File: tb/tb_cpu_controller.sv
// Bench for the CPU phase sequencer: constant-table instruction sequences,
// hand-written halt / async-reset / single-step sequences, then random opcodes
// checked against a behavioural model of the instruction cycle.
module tb_cpu_controller;
    logic clk = 1'b0;
    logic rst_;
    always #5 clk = ~clk;

    cpu_ctrl_if #(.OP_W(3), .PHASE_W(3)) bus ();

    cpu_controller #(.OP_W(3), .PHASE_W(3)) dut (
        .clk  (clk),
        .rst_ (rst_),
        .bus  (bus)
    );

    int n_chk = 0;
    int n_err = 0;

    // Model state: where in the instruction cycle we are, halted, parked for step.
    int m_ph;
    bit m_halt;
    bit m_wait;

    typedef struct {
        logic [2:0] op;
        logic       z;
        int         ph;
        logic [8:0] exp;
    } vec_t;
    vec_t vecs[$];

    // Strobe vector order: sel rd ld_ir inc_pc ld_pc ld_ac data_e wr halt
    function automatic logic [8:0] got_s();
        return {bus.sel, bus.rd, bus.ld_ir, bus.inc_pc, bus.ld_pc,
                bus.ld_ac, bus.data_e, bus.wr, bus.halt};
    endfunction

    function automatic logic [8:0] m_exp();
        int  op;
        bit  alu, skz, sto, jmp;
        op  = int'(bus.opcode);
        alu = (op >= 2 && op <= 5);
        skz = (op == 1);
        sto = (op == 6);
        jmp = (op == 7);
        if (m_halt) return 9'b000000001;
        case (m_ph)
            0: return 9'b100000000;
            1: return 9'b110000000;
            2, 3: return 9'b111000000;
            4: return {3'b000, 1'b1, 4'b0000, (op == 0)};
            5: return {1'b0, alu, 7'b0};
            6: return {1'b0, alu, 1'b0, skz && bus.zero, jmp, alu, sto, 2'b00};
            default: return {1'b0, alu, 1'b0, jmp, jmp, alu, sto, sto, 1'b0};
        endcase
    endfunction

    function automatic void m_reset();
        m_ph   = 0;
        m_halt = 0;
        m_wait = 0;
    endfunction

    // Instruction-cycle rules: 8 phases per instruction, HLT seen in phase 4 freezes at 5.
    function automatic void m_adv();
        bit stp;
`ifdef SINGLE_STEP_EN
        stp = bus.step;
`else
        stp = 1'b1;
`endif
        if (m_halt) return;
        if (m_ph == 4 && bus.opcode == 3'd0) begin
            m_halt = 1;
            m_ph   = 5;
        end else if (m_ph == 0 && m_wait && !stp) begin
            m_ph = 0;
        end else begin
`ifdef SINGLE_STEP_EN
            m_wait = (m_ph == 7);
`endif
            m_ph = (m_ph + 1) % 8;
        end
    endfunction

    task automatic chk(input string nm, input logic [8:0] es, input int eph);
        n_chk++;
        if (got_s() !== es) begin
            n_err++;
            $display("FAIL %s: strobes got %b want %b (sel rd ld_ir inc_pc ld_pc ld_ac data_e wr halt) t=%0t",
                     nm, got_s(), es, $time);
        end
        n_chk++;
        if (int'(bus.phase) != eph) begin
            n_err++;
            $display("FAIL %s: phase got %0d want %0d t=%0t", nm, bus.phase, eph, $time);
        end
    endtask

    // Inputs are already applied; check settled outputs, then take one clock edge.
    task automatic cyc(input string nm, input logic [8:0] es, input int eph);
        #1;
        chk(nm, es, eph);
        @(posedge clk);
        m_adv();
        #1;
    endtask

    task automatic cyc_m(input string nm);
        #1;
        chk(nm, m_exp(), m_ph);
        @(posedge clk);
        m_adv();
        #1;
    endtask

    // Assert reset asynchronously, optionally across edges, check, release at a falling edge.
    task automatic do_reset(input string nm, input int edges);
        rst_ = 1'b0;
        m_reset();
        #1;
        chk(nm, 9'b100000000, 0);
        repeat (edges) @(posedge clk);
        #1;
        if (edges > 0) chk({nm, "_held"}, 9'b100000000, 0);
        @(negedge clk);
        rst_ = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", n_err);
        $fatal(1, "timeout");
    end

    initial begin
        logic [2:0] ops  [5];
        logic       zs   [5];
        logic [8:0] tail [5][4];
        logic [8:0] fetch [4];

        rst_       = 1'b0;
        bus.opcode = 3'd2;
        bus.zero   = 1'b0;
`ifdef SINGLE_STEP_EN
        bus.step   = 1'b1;
`endif

        fetch = '{9'b100000000, 9'b110000000, 9'b111000000, 9'b111000000};
        ops   = '{3'd2, 3'd1, 3'd1, 3'd6, 3'd7};
        zs    = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        tail[0] = '{9'b000100000, 9'b010000000, 9'b010001000, 9'b010001000}; // ADD
        tail[1] = '{9'b000100000, 9'b000000000, 9'b000100000, 9'b000000000}; // SKZ z=1
        tail[2] = '{9'b000100000, 9'b000000000, 9'b000000000, 9'b000000000}; // SKZ z=0
        tail[3] = '{9'b000100000, 9'b000000000, 9'b000000100, 9'b000000110}; // STO
        tail[4] = '{9'b000100000, 9'b000000000, 9'b000010000, 9'b000110000}; // JMP
        for (int i = 0; i < 5; i++) begin
            for (int p = 0; p < 8; p++) begin
                vec_t v;
                v.op  = ops[i];
                v.z   = zs[i];
                v.ph  = p;
                v.exp = (p < 4) ? fetch[p] : tail[i][p-4];
                vecs.push_back(v);
            end
        end

        // Reset held across edges, then five back-to-back instructions.
        do_reset("reset", 3);
        foreach (vecs[i]) begin
            bus.opcode = vecs[i].op;
            bus.zero   = vecs[i].z;
            cyc($sformatf("table%0d", i), vecs[i].exp, vecs[i].ph);
        end
        #1;
        chk("wrap", 9'b100000000, 0);

        // HLT: halt shows in phase 4, then frozen at phase 5 with only halt high.
        do_reset("rst_hlt", 0);
        bus.opcode = 3'd0;
        for (int p = 0; p < 4; p++) cyc_m("hlt_fetch");
        cyc("hlt_ph4", 9'b000100001, 4);
        for (int k = 0; k < 22; k++) begin
            bus.opcode = 3'($urandom_range(0, 7));
            bus.zero   = 1'($urandom_range(0, 1));
`ifdef SINGLE_STEP_EN
            bus.step   = 1'($urandom_range(0, 1));
`endif
            cyc("hlt_hold", 9'b000000001, 5);
        end
`ifdef SINGLE_STEP_EN
        bus.step = 1'b1;
`endif
        do_reset("rst_while_halted", 0);

        // Async reset in the middle of phase 6 of an ADD.
        bus.opcode = 3'd2;
        for (int p = 0; p < 6; p++) cyc_m("pre_mid");
        #1;
        chk("at_ph6", 9'b010001000, 6);
        do_reset("rst_mid_ph6", 0);
        cyc("after_rst", 9'b100000000, 0);
        #1;
        chk("first_adv", 9'b110000000, 1);

`ifdef SINGLE_STEP_EN
        // Single step: park at 0 after the first instruction; one step pulse = one instruction.
        do_reset("rst_step", 0);
        bus.step   = 1'b0;
        bus.opcode = 3'd2;
        for (int p = 0; p < 8; p++) cyc("ss_first", fetch[p < 4 ? p : 0] & ((p < 4) ? 9'h1FF : 9'h000) | ((p >= 4) ? tail[0][p < 4 ? 0 : p-4] : 9'h000), p);
        for (int k = 0; k < 5; k++) cyc("ss_parked", 9'b100000000, 0);
        bus.step = 1'b1;
        cyc("ss_pulse", 9'b100000000, 0);
        bus.step = 1'b0;
        for (int p = 1; p < 8; p++) cyc("ss_one_instr", (p < 4) ? fetch[p] : tail[0][p-4], p);
        for (int k = 0; k < 4; k++) cyc("ss_parked2", 9'b100000000, 0);
`endif

        // Random opcodes/zero with occasional async resets, against the model.
        do_reset("rst_rand", 0);
        for (int k = 0; k < 3000; k++) begin
            int op;
            op = $urandom_range(0, 7);
            if (op == 0 && $urandom_range(0, 7) != 0) op = 2;
            bus.opcode = 3'(op);
            bus.zero   = 1'($urandom_range(0, 1));
`ifdef SINGLE_STEP_EN
            bus.step   = ($urandom_range(0, 3) == 0);
`endif
            if ($urandom_range(0, 99) == 0 || (m_halt && $urandom_range(0, 15) == 0)) begin
                do_reset("rand_rst", 0);
            end else begin
                cyc_m("rand");
            end
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
